// File: rtl/q_capture_pkg.sv
// q_change_capture shared types and defaults.
// Widths and limits used by the capture top and its FIFO.
package q_capture_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0] sample_t;

  localparam sample_t DEF_MASK = 4'hF;

  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO.
// Head is muxed from storage and forced to zero when empty.
import q_capture_pkg::*;

module capture_fifo #(
  parameter int W     = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr;
  logic [PW:0]  rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
    end
  end

  // Storage carries no reset; only slots below wr are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push)
      mem[wr[PW-1:0]] <= wdata;
  end

  assign empty = (wr == rd);
  assign full  = (wr[PW] != rd[PW]) &&
                 (wr[PW-1:0] == rd[PW-1:0]);
  assign level = wr - rd;
  assign rdata = empty ? '0 : mem[rd[PW-1:0]];

endmodule

// File: rtl/q_change_capture.sv
// Masked change detector on the q1..q4 sample bus.
// Changes queue into a FIFO with a saturating count and sticky overflow.
import q_capture_pkg::*;

module q_change_capture #(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               DEPTH = DEF_DEPTH,
  parameter int               CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] MASK  = DEF_MASK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       q_in,
  input  logic                   in_en,
  input  logic                   flush,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       change_cnt
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [WIDTH-1:0] prev;
  logic             hist_vld;
  logic             change;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign change = in_en &&
                  (!hist_vld || ((q_in ^ prev) & MASK) != '0);
  assign pop    = !empty && out_ready && !flush;
  assign push   = change && (!full || pop) && !flush;

  assign out_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      hist_vld   <= 1'b0;
      overflow   <= 1'b0;
      change_cnt <= '0;
    end else if (flush) begin
      hist_vld   <= 1'b0;
      overflow   <= 1'b0;
      change_cnt <= '0;
    end else begin
      if (in_en) begin
        prev     <= q_in;
        hist_vld <= 1'b1;
      end
      if (change && change_cnt != SAT)
        change_cnt <= change_cnt + 1'b1;
      if (change && full && !pop)
        overflow <= 1'b1;
    end
  end

  capture_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (q_in),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_q_change_capture.sv
// Directed bench for q_change_capture with queue scoreboards.
// Three instances: default, single-bit mask, 3-bit counter.
module tb_q_change_capture;

  logic       clk;
  logic       rst_n;
  logic [3:0] q_in;
  logic       in_en;
  logic       flush;
  logic       rdy0, rdy1, rdy2;

  logic [3:0] data0, data1, data2;
  logic       vld0, vld1, vld2;
  logic [3:0] lvl0, lvl1, lvl2;
  logic       ovf0, ovf1, ovf2;
  logic [7:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int nchk;
  int nfail;

  logic [3:0] exp0 [$];
  logic [3:0] exp1 [$];

  q_change_capture d0 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .in_en(in_en),
    .flush(flush), .out_data(data0), .out_valid(vld0),
    .out_ready(rdy0), .level(lvl0), .overflow(ovf0),
    .change_cnt(cnt0)
  );

  q_change_capture #(.MASK(4'b0001)) d1 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .in_en(in_en),
    .flush(flush), .out_data(data1), .out_valid(vld1),
    .out_ready(rdy1), .level(lvl1), .overflow(ovf1),
    .change_cnt(cnt1)
  );

  q_change_capture #(.CNT_W(3)) d2 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .in_en(in_en),
    .flush(flush), .out_data(data2), .out_valid(vld2),
    .out_ready(rdy2), .level(lvl2), .overflow(ovf2),
    .change_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input string tag,
                         input logic [3:0] obs,
                         inout logic [3:0] q [$]);
    logic [3:0] e;
    if (q.size() == 0) begin
      chk({tag, "_underflow"}, 16'(q.size()), 16'd1);
    end else begin
      e = q.pop_front();
      chk(tag, {12'd0, obs}, {12'd0, e});
    end
  endtask

  // Drive, score any pop the coming edge performs, then sample after it.
  task automatic step(input logic [3:0] q,
                      input logic en,
                      input logic fl);
    q_in  = q;
    in_en = en;
    flush = fl;
    if (vld0 && rdy0 && !fl && rst_n) pop_chk("pop0", data0, exp0);
    if (vld1 && rdy1 && !fl && rst_n) pop_chk("pop1", data1, exp1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    rst_n = 1'b0;
    q_in  = '0;
    in_en = 1'b0;
    flush = 1'b0;
    rdy0  = 1'b0;
    rdy1  = 1'b0;
    rdy2  = 1'b0;
    @(posedge clk); #1;
    step(4'h0, 1'b0, 1'b0);
    chk("rst_valid", 16'(vld0), 16'd0);
    chk("rst_data",  16'(data0), 16'd0);
    chk("rst_level", 16'(lvl0), 16'd0);
    chk("rst_ovf",   16'(ovf0), 16'd0);
    chk("rst_cnt",   16'(cnt0), 16'd0);
    rst_n = 1'b1;
    step(4'h0, 1'b0, 1'b0);

    // 1: held value yields one push
    exp0.push_back(4'h3);
    step(4'h3, 1'b1, 1'b0);
    chk("t1_valid", 16'(vld0), 16'd1);
    chk("t1_data",  16'(data0), 16'h3);
    chk("t1_level", 16'(lvl0), 16'd1);
    chk("t1_cnt",   16'(cnt0), 16'd1);
    for (int i = 0; i < 3; i++) step(4'h3, 1'b1, 1'b0);
    chk("t1_level_hold", 16'(lvl0), 16'd1);
    chk("t1_cnt_hold",   16'(cnt0), 16'd1);
    rdy0 = 1'b1;
    step(4'h3, 1'b0, 1'b0);
    rdy0 = 1'b0;
    chk("t1_empty_valid", 16'(vld0), 16'd0);
    chk("t1_empty_data",  16'(data0), 16'd0);
    chk("t1_empty_level", 16'(lvl0), 16'd0);

    // 2: mask=0001; history follows every enabled sample
    step(4'h0, 1'b0, 1'b1);
    exp1.push_back(4'h0);
    step(4'h0, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    exp1.push_back(4'h3);
    step(4'h3, 1'b1, 1'b0);
    step(4'h1, 1'b1, 1'b0);
    chk("t2_cnt_a",   16'(cnt1), 16'd2);
    chk("t2_level_a", 16'(lvl1), 16'd2);
    exp1.push_back(4'h0);
    step(4'h0, 1'b1, 1'b0);
    chk("t2_cnt_b", 16'(cnt1), 16'd3);
    rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b0);
    rdy1 = 1'b0;
    chk("t2_drained", 16'(lvl1), 16'd0);

    // 3: overfill default FIFO
    step(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp0.push_back(i[0] ? 4'hA : 4'h5);
      step(i[0] ? 4'hA : 4'h5, 1'b1, 1'b0);
    end
    chk("t3_level", 16'(lvl0), 16'd8);
    chk("t3_ovf",   16'(ovf0), 16'd1);
    chk("t3_cnt",   16'(cnt0), 16'd10);

    // 4: full with simultaneous pop and push
    rdy0 = 1'b1;
    exp0.push_back(4'hC);
    step(4'hC, 1'b1, 1'b0);
    chk("t4_level", 16'(lvl0), 16'd8);
    chk("t4_ovf",   16'(ovf0), 16'd1);
    chk("t4_cnt",   16'(cnt0), 16'd11);
    for (int i = 0; i < 8; i++) step(4'hC, 1'b0, 1'b0);
    rdy0 = 1'b0;
    chk("t4_drained", 16'(lvl0), 16'd0);
    chk("t4_sb_left", 16'(exp0.size()), 16'd0);

    // 5: 3-bit counter saturates
    step(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(i[0] ? 4'h2 : 4'h1, 1'b1, 1'b0);
      if (i == 6) chk("t5_cnt7", 16'(cnt2), 16'd7);
    end
    chk("t5_sat", 16'(cnt2), 16'd7);
    chk("t5_ovf", 16'(ovf2), 16'd1);

    // 6a: flush coincident with a change
    step(4'h0, 1'b0, 1'b1);
    step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    step(4'h9, 1'b1, 1'b1);
    chk("t6f_level", 16'(lvl0), 16'd0);
    chk("t6f_valid", 16'(vld0), 16'd0);
    chk("t6f_data",  16'(data0), 16'd0);
    chk("t6f_cnt",   16'(cnt0), 16'd0);
    exp0.push_back(4'h9);
    step(4'h9, 1'b1, 1'b0);
    chk("t6f_push",  16'(data0), 16'h9);
    chk("t6f_cnt1",  16'(cnt0), 16'd1);
    rdy0 = 1'b1;
    step(4'h9, 1'b0, 1'b0);
    rdy0 = 1'b0;

    // 6b: same with reset
    step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(4'h9, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("t6r_level", 16'(lvl0), 16'd0);
    chk("t6r_valid", 16'(vld0), 16'd0);
    chk("t6r_data",  16'(data0), 16'd0);
    chk("t6r_cnt",   16'(cnt0), 16'd0);
    chk("t6r_ovf",   16'(ovf0), 16'd0);
    exp0.push_back(4'h9);
    step(4'h9, 1'b1, 1'b0);
    chk("t6r_push",  16'(data0), 16'h9);
    chk("t6r_level1", 16'(lvl0), 16'd1);
    rdy0 = 1'b1;
    step(4'h9, 1'b0, 1'b0);
    rdy0 = 1'b0;
    chk("t6r_sb_left", 16'(exp0.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
